// File: rtl/axis_decimator_pkg.sv
// Shared constants and types for the AXI-Stream decimator slice.
package axis_decimator_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 16;
    localparam int unsigned RATIO_W_DEFAULT = 8;
    localparam int unsigned KEPT_CNT_W      = 16;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] tdata;
        logic                      tlast;
    } skid_entry_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered AXI-Stream slice: output register plus one skid entry,
// with a registered upstream ready that is high whenever the skid entry is free.
module axis_skid_buffer
    import axis_decimator_pkg::*;
#(
    parameter int unsigned payload_width = DATA_W_DEFAULT + 1
) (
    input  logic                     aclk,
    input  logic                     resetn,
    input  logic [payload_width-1:0] in_payload,
    input  logic                     in_push,
    output logic                     in_ready,
    output logic [payload_width-1:0] out_payload,
    output logic                     out_valid,
    input  logic                     out_ready
);

    skid_state_e              state_q, state_d;
    logic [payload_width-1:0] or_q, or_d;
    logic [payload_width-1:0] sk_q, sk_d;
    logic                     ready_q, ready_d;
    logic                     pop;

    always_comb begin
        pop     = (state_q != SKID_EMPTY) && out_ready;
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        case (state_q)
            SKID_EMPTY: begin
                if (in_push) begin
                    or_d    = in_payload;
                    state_d = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (in_push && pop) begin
                    or_d = in_payload;
                end else if (in_push) begin
                    sk_d    = in_payload;
                    state_d = SKID_FULL;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_push cannot occur here: in_ready is low while the skid entry is occupied
                if (pop) begin
                    or_d    = sk_q;
                    state_d = SKID_ONE;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
        ready_d = (state_d != SKID_FULL);
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q <= SKID_EMPTY;
            or_q    <= '0;
            sk_q    <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            or_q    <= or_d;
            sk_q    <= sk_d;
            ready_q <= ready_d;
        end
    end

    assign out_valid   = (state_q != SKID_EMPTY);
    assign out_payload = or_q;
    assign in_ready    = ready_q;

endmodule

// File: rtl/axis_decimator.sv
// AXI-Stream integer decimator: keeps one of every R accepted samples, always
// keeps tlast samples, and restarts the phase at each frame boundary.
module axis_decimator
    import axis_decimator_pkg::*;
#(
    parameter int unsigned data_width  = DATA_W_DEFAULT,
    parameter int unsigned ratio_width = RATIO_W_DEFAULT
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic [data_width-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [data_width-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic [ratio_width-1:0] decimation_ratio,
    output logic [KEPT_CNT_W-1:0]  kept_count
);

    logic [ratio_width-1:0] cnt_q, cnt_d;
    logic [ratio_width-1:0] ratio_q, ratio_d;
    logic [KEPT_CNT_W-1:0]  kept_count_q, kept_count_d;
    logic                   accept;
    logic                   keep;
    logic [data_width:0]    out_payload;

    always_comb begin
        accept       = s_axis_tvalid && s_axis_tready;
        keep         = accept && ((cnt_q == '0) || s_axis_tlast);
        cnt_d        = cnt_q;
        ratio_d      = ratio_q;
        kept_count_d = kept_count_q;
        if (accept) begin
            if (s_axis_tlast || (ratio_q <= ratio_width'(1)) || (cnt_q == ratio_q - ratio_width'(1))) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + ratio_width'(1);
            end
        end
        // Ratio only reloads on a kept sample so a period is never cut short mid-way
        if (keep) begin
            ratio_d      = decimation_ratio;
            kept_count_d = kept_count_q + KEPT_CNT_W'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            cnt_q        <= '0;
            ratio_q      <= decimation_ratio;
            kept_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            ratio_q      <= ratio_d;
            kept_count_q <= kept_count_d;
        end
    end

    axis_skid_buffer #(
        .payload_width(data_width + 1)
    ) u_skid (
        .aclk       (aclk),
        .resetn     (resetn),
        .in_payload ({s_axis_tdata, s_axis_tlast}),
        .in_push    (keep),
        .in_ready   (s_axis_tready),
        .out_payload(out_payload),
        .out_valid  (m_axis_tvalid),
        .out_ready  (m_axis_tready)
    );

    assign m_axis_tdata = out_payload[data_width:1];
    assign m_axis_tlast = out_payload[0];
    assign kept_count   = kept_count_q;

endmodule

// File: tb/tb_axis_decimator.sv
// Directed bench for axis_decimator: ratio sweep, frame restart, backpressure,
// runtime ratio change and mid-stream reset.
module tb_axis_decimator;
    import axis_decimator_pkg::*;

    logic        aclk;
    logic        resetn;
    logic [15:0] s_tdata;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] m_tdata;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  decimation_ratio;
    logic [15:0] kept_count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned stalls = 0;

    skid_entry_t rx_q[$];
    skid_entry_t exp_q[$];

    axis_decimator #(
        .data_width (16),
        .ratio_width(8)
    ) dut (
        .aclk            (aclk),
        .resetn          (resetn),
        .s_axis_tdata    (s_tdata),
        .s_axis_tlast    (s_tlast),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tlast    (m_tlast),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .decimation_ratio(decimation_ratio),
        .kept_count      (kept_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (resetn && m_tvalid && m_tready) rx_q.push_back('{tdata: m_tdata, tlast: m_tlast});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input logic [15:0] d, input logic l);
        exp_q.push_back('{tdata: d, tlast: l});
    endtask

    // Holds one sample on the slave port until it is accepted.
    task automatic send(input logic [15:0] d, input logic l);
        int unsigned n;
        logic rdy;
        n = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        do begin
            @(negedge aclk);
            rdy = s_tready;
            @(posedge aclk);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) chk("send_timeout", 32'(rdy), 32'd1);
        if (n > 1) stalls++;
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (m_tvalid && n < 100) begin
            @(negedge aclk);
            n++;
        end
        if (m_tvalid) chk("drain_timeout", 32'(m_tvalid), 32'd0);
    endtask

    task automatic check_rx(input string tag);
        chk($sformatf("%s_count", tag), rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic reset_dut(input logic [7:0] r);
        decimation_ratio = r;
        s_tvalid = 1'b0;
        resetn   = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_kept_count", 32'(kept_count), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rst_release_s_tready", 32'(s_tready), 32'd1);
        rx_q.delete();
        exp_q.delete();
        stalls = 0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        s_tdata = '0;
        s_tlast = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        decimation_ratio = 8'd4;

        // R=4 continuous ramp
        reset_dut(8'd4);
        m_tready = 1'b1;
        for (int i = 0; i < 16; i++) send(16'(i), 1'b0);
        drain();
        expect_out(16'd0, 1'b0);
        expect_out(16'd4, 1'b0);
        expect_out(16'd8, 1'b0);
        expect_out(16'd12, 1'b0);
        check_rx("r4_ramp");
        chk("r4_kept_count", 32'(kept_count), 32'd4);
        chk("r4_no_stall", stalls, 32'd0);

        // R=1 then R=0: pass-through with one cycle latency
        reset_dut(8'd1);
        for (int i = 100; i <= 104; i++) begin
            send(16'(i), 1'b0);
            chk("r1_latency_valid", 32'(m_tvalid), 32'd1);
            chk("r1_latency_data", 32'(m_tdata), 32'(i));
            expect_out(16'(i), 1'b0);
        end
        decimation_ratio = 8'd0;
        for (int i = 100; i <= 104; i++) begin
            send(16'(i), 1'b0);
            chk("r0_latency_data", 32'(m_tdata), 32'(i));
            expect_out(16'(i), 1'b0);
        end
        drain();
        check_rx("passthru");
        chk("passthru_kept_count", 32'(kept_count), 32'd10);

        // R=3 with tlast on sample 4
        reset_dut(8'd3);
        for (int i = 0; i < 8; i++) send(16'(i), i == 4);
        drain();
        expect_out(16'd0, 1'b0);
        expect_out(16'd3, 1'b0);
        expect_out(16'd4, 1'b1);
        expect_out(16'd5, 1'b0);
        check_rx("r3_tlast");

        // R=2 with downstream stalled
        reset_dut(8'd2);
        m_tready = 1'b0;
        send(16'd0, 1'b0);
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        chk("bp_sk_full_tready", 32'(s_tready), 32'd0);
        fork
            begin
                for (int i = 3; i < 10; i++) send(16'(i), 1'b0);
            end
            begin
                repeat (3) begin
                    @(negedge aclk);
                    chk("bp_hold_valid", 32'(m_tvalid), 32'd1);
                    chk("bp_hold_data", 32'(m_tdata), 32'd0);
                    chk("bp_hold_tready", 32'(s_tready), 32'd0);
                end
                @(posedge aclk);
                #1;
                m_tready = 1'b1;
            end
        join
        drain();
        for (int i = 0; i < 10; i += 2) expect_out(16'(i), 1'b0);
        check_rx("bp");
        chk("bp_kept_count", 32'(kept_count), 32'd5);

        // Ratio change 2 -> 5 applies from the next kept sample
        reset_dut(8'd2);
        send(16'd0, 1'b0);
        send(16'd1, 1'b0);
        decimation_ratio = 8'd5;
        for (int i = 2; i <= 12; i++) send(16'(i), 1'b0);
        drain();
        expect_out(16'd0, 1'b0);
        expect_out(16'd2, 1'b0);
        expect_out(16'd7, 1'b0);
        expect_out(16'd12, 1'b0);
        check_rx("ratio_chg");

        // Reset with both buffer entries occupied
        reset_dut(8'd2);
        m_tready = 1'b0;
        send(16'd0, 1'b0);
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        chk("mid_full_valid", 32'(m_tvalid), 32'd1);
        chk("mid_full_tready", 32'(s_tready), 32'd0);
        decimation_ratio = 8'd3;
        resetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("mid_rst_valid", 32'(m_tvalid), 32'd0);
        chk("mid_rst_tready", 32'(s_tready), 32'd0);
        chk("mid_rst_kept", 32'(kept_count), 32'd0);
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("mid_rel_tready", 32'(s_tready), 32'd1);
        chk("mid_rel_valid", 32'(m_tvalid), 32'd0);
        rx_q.delete();
        exp_q.delete();
        m_tready = 1'b1;
        send(16'd50, 1'b0);
        chk("mid_first_kept", 32'(m_tdata), 32'd50);
        for (int i = 51; i <= 53; i++) send(16'(i), 1'b0);
        drain();
        expect_out(16'd50, 1'b0);
        expect_out(16'd53, 1'b0);
        check_rx("mid_rst");
        chk("mid_kept_count", 32'(kept_count), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
